lcd_refresh_ctrl: RTL and testbench

//  Sequences the LCD character driver so NUM_REGS CPU registers are shown as 2-digit hex.

---
 rtl/lcd_pkg.sv | 26 ++
 rtl/lcd_refresh_ctrl_rr_pick.sv | 34 +++
 rtl/lcd_refresh_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_lcd_refresh_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD refresh controller: FSM states,
// ASCII constants and the nibble-to-hex-character helper.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SEND_HI,
    ST_GAP_HI,
    ST_SEND_LO,
    ST_GAP_LO
  } state_t;

  localparam int unsigned IDX_W         = 3;
  localparam int unsigned MAX_REGS      = 8;
  localparam logic [7:0]  ASCII_SPACE   = 8'h20;
  localparam logic [7:0]  ASCII_ZERO    = 8'h30;
  localparam logic [7:0]  HEX_ALPHA_OFF = 8'h37;
  localparam logic [3:0]  HEX_DEC_LIMIT = 4'd10;

  // '0'..'9' for 0..9, 'A'..'F' for 10..15
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < HEX_DEC_LIMIT) ? (ASCII_ZERO + 8'(n)) : (HEX_ALPHA_OFF + 8'(n));
  endfunction

endpackage

// File: rtl/lcd_refresh_ctrl_rr_pick.sv
// Round-robin first-set finder: lowest request index at or after ptr,
// wrapping at N.
module rr_pick
  import lcd_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [MAX_REGS-1:0] req8;
  logic [IDX_W:0]      pos;

  assign req8 = MAX_REGS'(req);

  // Scan from the far end so the closest hit to ptr is written last
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    pos       = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(N)) pos = pos - (IDX_W + 1)'(N);
      if (req8[pos[IDX_W-1:0]]) begin
        grant_idx = pos[IDX_W-1:0];
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// Refreshes NUM_REGS register values onto the LCD as 2-digit hex through the
// character driver. Optional watchdog on driver completion: LCD_WATCHDOG_EN.
module lcd_refresh_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 4,
  parameter logic [7:0]  BASE_ADDR  = 8'h00,
  parameter int unsigned INIT_WAIT  = 2000,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 8000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REGS*8-1:0] reg_flat,
  input  logic                  refresh,
  output logic                  drv_start,
  output logic                  drv_loc_req,
  output logic [7:0]            drv_data,
  output logic [7:0]            drv_char_loc,
  input  logic                  drv_done_tick,
  output logic                  busy,
  output logic [2:0]            cur_reg,
  output logic                  err
);

  localparam int unsigned CNT_MAX0 = (INIT_WAIT > GAP_CYCLES) ? INIT_WAIT : GAP_CYCLES;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > TIMEOUT) ? CNT_MAX0 : TIMEOUT;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          snap_q, snap_d;
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [NUM_REGS-1:0] force_q, force_d, clr_mask, dirty;
  logic [7:0]          shadow_q [MAX_REGS];
  logic                shadow_we;
  logic [7:0]          regs [MAX_REGS];
  logic [7:0]          sel_val;
  logic                start_q, start_d, loc_q, loc_d, busy_q, busy_d, done_q, done_rise;
  logic [7:0]          data_q, data_d, char_loc_q, char_loc_d;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_vld;
`ifdef LCD_WATCHDOG_EN
  logic                err_q, err_set;
`endif

  // Pad register taps to a fixed 8-entry view so a 3-bit index always fits
  for (genvar g = 0; g < int'(MAX_REGS); g++) begin : g_regs
    if (g < int'(NUM_REGS)) begin : g_live
      assign regs[g] = reg_flat[8*g +: 8];
    end else begin : g_pad
      assign regs[g] = '0;
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_dirty
    assign dirty[g] = force_q[g] | (regs[g] != shadow_q[g]);
  end

  rr_pick #(.N(NUM_REGS)) u_rr_pick (
    .req       (dirty),
    .ptr       (rr_q),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign sel_val   = regs[grant_idx];
  assign done_rise = drv_done_tick & ~done_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    snap_d     = snap_q;
    cur_d      = cur_q;
    rr_d       = rr_q;
    clr_mask   = '0;
    shadow_we  = 1'b0;
    start_d    = start_q;
    loc_d      = loc_q;
    data_d     = data_q;
    char_loc_d = char_loc_q;
`ifdef LCD_WATCHDOG_EN
    err_set    = 1'b0;
`endif
    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_W'(INIT_WAIT - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (grant_vld) begin
          snap_d     = sel_val;
          cur_d      = grant_idx;
          char_loc_d = BASE_ADDR + (8'(grant_idx) * 8'd3);
          data_d     = hex_ascii(sel_val[7:4]);
          loc_d      = 1'b1;
          start_d    = 1'b1;
          cnt_d      = '0;
          state_d    = ST_SEND_HI;
        end
      end
      ST_SEND_HI: begin
        if (done_rise) begin
          start_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_GAP_HI;
        end
`ifdef LCD_WATCHDOG_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          start_d = 1'b0;
          err_set = 1'b1;
          cnt_d   = '0;
          state_d = ST_GAP_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_GAP_HI: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          start_d = 1'b1;
          loc_d   = 1'b0;
          data_d  = hex_ascii(snap_q[3:0]);
          cnt_d   = '0;
          state_d = ST_SEND_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SEND_LO: begin
        // Shadow takes the value actually sent, so a change mid-update stays dirty
        if (done_rise) begin
          start_d   = 1'b0;
          shadow_we = 1'b1;
          clr_mask  = NUM_REGS'(1) << cur_q;
          rr_d      = (cur_q == IDX_W'(NUM_REGS - 1)) ? '0 : cur_q + IDX_W'(1);
          cnt_d     = '0;
          state_d   = ST_GAP_LO;
        end
`ifdef LCD_WATCHDOG_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          start_d = 1'b0;
          err_set = 1'b1;
          cnt_d   = '0;
          state_d = ST_GAP_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_GAP_LO: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_INIT;
      end
    endcase
    force_d = (force_q & ~clr_mask) | {NUM_REGS{refresh}};
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      snap_q     <= '0;
      cur_q      <= '0;
      rr_q       <= '0;
      force_q    <= '1;
      start_q    <= 1'b0;
      loc_q      <= 1'b0;
      data_q     <= ASCII_SPACE;
      char_loc_q <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      for (int i = 0; i < int'(MAX_REGS); i++) shadow_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      cur_q      <= cur_d;
      rr_q       <= rr_d;
      force_q    <= force_d;
      start_q    <= start_d;
      loc_q      <= loc_d;
      data_q     <= data_d;
      char_loc_q <= char_loc_d;
      busy_q     <= busy_d;
      done_q     <= drv_done_tick;
      if (shadow_we) shadow_q[cur_q] <= snap_q;
    end
  end

`ifdef LCD_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_q | err_set;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign drv_start    = start_q;
  assign drv_loc_req  = loc_q;
  assign drv_data     = data_q;
  assign drv_char_loc = char_loc_q;
  assign busy         = busy_q;
  assign cur_reg      = cur_q;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Directed bench for lcd_refresh_ctrl with a simple LCD driver responder;
// watchdog scenario only when LCD_WATCHDOG_EN is defined.
module tb_lcd_refresh_ctrl;

  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned INIT_WAIT = 2000;
  localparam int unsigned TIMEOUT   = 8000;

  typedef struct {
    logic       loc;
    logic [7:0] addr;
    logic [7:0] data;
    logic [2:0] idx;
  } txn_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REGS*8-1:0] reg_flat;
  logic                  refresh;
  logic                  drv_start, drv_loc_req, drv_done_tick, busy, err;
  logic [7:0]            drv_data, drv_char_loc;
  logic [2:0]            cur_reg;
  logic                  drv_en;

  txn_t txq[$];
  txn_t exq[$];
  int   n_vec = 0;
  int   n_err = 0;

  lcd_refresh_ctrl #(
    .NUM_REGS(NUM_REGS), .BASE_ADDR(8'h00), .INIT_WAIT(INIT_WAIT),
    .GAP_CYCLES(4), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .reg_flat(reg_flat), .refresh(refresh),
    .drv_start(drv_start), .drv_loc_req(drv_loc_req), .drv_data(drv_data),
    .drv_char_loc(drv_char_loc), .drv_done_tick(drv_done_tick), .busy(busy),
    .cur_reg(cur_reg), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver model: completes each request 3 cycles after it is seen
  initial begin
    int   lat;
    txn_t t;
    drv_done_tick = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      if (drv_start && drv_en && !drv_done_tick) begin
        if (lat == 2) begin
          t.loc = drv_loc_req; t.addr = drv_char_loc; t.data = drv_data; t.idx = cur_reg;
          txq.push_back(t);
          drv_done_tick = 1'b1;
          lat = 0;
        end else begin
          lat++;
        end
      end else begin
        drv_done_tick = 1'b0;
        lat = 0;
      end
    end
  end

  task automatic add_exp(input logic loc, input logic [7:0] addr, input logic [7:0] data,
                         input logic [2:0] idx);
    txn_t t;
    t.loc = loc; t.addr = addr; t.data = data; t.idx = idx;
    exq.push_back(t);
  endtask

  task automatic set_reg(input int i, input logic [7:0] v);
    reg_flat[8*i +: 8] = v;
  endtask

  // Wait until the controller has been idle and quiet for a while
  task automatic settle(input string tag);
    int quiet = 0;
    int t = 0;
    while (quiet < 12 && t < 5000) begin
      @(negedge clk);
      t++;
      if (!busy && !drv_start) quiet++;
      else quiet = 0;
    end
    check({tag, ".settle"}, 32'(quiet >= 12), 32'd1);
  endtask

  task automatic compare_txns(input string tag);
    int n;
    check({tag, ".count"}, 32'(txq.size()), 32'(exq.size()));
    n = (txq.size() < exq.size()) ? txq.size() : exq.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d].loc", tag, i), 32'(txq[i].loc), 32'(exq[i].loc));
      check($sformatf("%s[%0d].data", tag, i), 32'(txq[i].data), 32'(exq[i].data));
      check($sformatf("%s[%0d].idx", tag, i), 32'(txq[i].idx), 32'(exq[i].idx));
      if (exq[i].loc)
        check($sformatf("%s[%0d].addr", tag, i), 32'(txq[i].addr), 32'(exq[i].addr));
    end
    txq.delete();
    exq.delete();
  endtask

  initial begin
    int t;
    rst_n = 1'b0; reg_flat = '0; refresh = 1'b0; drv_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.busy", 32'(busy), 32'd1);
    check("rst.start", 32'(drv_start), 32'd0);
    check("rst.loc_req", 32'(drv_loc_req), 32'd0);
    check("rst.data", 32'(drv_data), 32'h20);
    check("rst.char_loc", 32'(drv_char_loc), 32'd0);
    check("rst.cur_reg", 32'(cur_reg), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // Still initialising just before INIT_WAIT elapses
    repeat (INIT_WAIT - 2) @(negedge clk);
    check("init.start", 32'(drv_start), 32'd0);
    check("init.busy", 32'(busy), 32'd1);

    // Power-up: all four forced, served 0..3
    for (int i = 0; i < 4; i++) begin
      add_exp(1'b1, 8'(3 * i), 8'h30, 3'(i));
      add_exp(1'b0, 8'h00, 8'h30, 3'(i));
    end
    settle("t1");
    compare_txns("t1");

    // Single change on reg2
    set_reg(2, 8'hA7);
    add_exp(1'b1, 8'h06, 8'h41, 3'd2);
    add_exp(1'b0, 8'h00, 8'h37, 3'd2);
    settle("t2");
    compare_txns("t2");

    // Move rr pointer to 2 by serving reg1
    set_reg(1, 8'h5C);
    add_exp(1'b1, 8'h03, 8'h35, 3'd1);
    add_exp(1'b0, 8'h00, 8'h43, 3'd1);
    settle("t3a");
    compare_txns("t3a");

    // Regs 1 and 3 change together with rr=2: reg3 first
    set_reg(1, 8'hF0);
    set_reg(3, 8'h9B);
    add_exp(1'b1, 8'h09, 8'h39, 3'd3);
    add_exp(1'b0, 8'h00, 8'h42, 3'd3);
    add_exp(1'b1, 8'h03, 8'h46, 3'd1);
    add_exp(1'b0, 8'h00, 8'h30, 3'd1);
    settle("t3");
    compare_txns("t3");

    // Reg0 changes during its own low-nibble write
    set_reg(0, 8'h12);
    t = 0;
    while (!(drv_start && !drv_loc_req) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("t4.reach_lo", 32'(drv_start && !drv_loc_req), 32'd1);
    set_reg(0, 8'h34);
    add_exp(1'b1, 8'h00, 8'h31, 3'd0);
    add_exp(1'b0, 8'h00, 8'h32, 3'd0);
    add_exp(1'b1, 8'h00, 8'h33, 3'd0);
    add_exp(1'b0, 8'h00, 8'h34, 3'd0);
    settle("t4");
    compare_txns("t4");

    // Refresh pulse with rr=1: 1,2,3,0 rewritten once each
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    add_exp(1'b1, 8'h03, 8'h46, 3'd1); add_exp(1'b0, 8'h00, 8'h30, 3'd1);
    add_exp(1'b1, 8'h06, 8'h41, 3'd2); add_exp(1'b0, 8'h00, 8'h37, 3'd2);
    add_exp(1'b1, 8'h09, 8'h39, 3'd3); add_exp(1'b0, 8'h00, 8'h42, 3'd3);
    add_exp(1'b1, 8'h00, 8'h33, 3'd0); add_exp(1'b0, 8'h00, 8'h34, 3'd0);
    settle("t5");
    compare_txns("t5");

`ifdef LCD_WATCHDOG_EN
    // Driver never completes: request held exactly TIMEOUT cycles, then retried
    drv_en = 1'b0;
    set_reg(0, 8'h77);
    t = 0;
    while (!drv_start && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t6.start", 32'(drv_start), 32'd1);
    t = 0;
    while (drv_start && t < int'(TIMEOUT) + 50) begin
      t++;
      @(negedge clk);
    end
    drv_en = 1'b1;
    check("t6.hold_len", 32'(t), 32'(TIMEOUT));
    check("t6.err", 32'(err), 32'd1);
    add_exp(1'b1, 8'h00, 8'h37, 3'd0);
    add_exp(1'b0, 8'h00, 8'h37, 3'd0);
    settle("t6");
    compare_txns("t6");
    check("t6.err_sticky", 32'(err), 32'd1);
`endif

    // Reset mid-transaction drops the request at the next edge
    set_reg(3, 8'h01);
    t = 0;
    while (!drv_start && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t7.start", 32'(drv_start), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t7.start_drop", 32'(drv_start), 32'd0);
    check("t7.busy", 32'(busy), 32'd1);
    check("t7.err", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
